// File: rtl/copy_pkg.sv
// Shared types for the copy engine command path.
// Command layout, scheduler states and engine-wide constants.
package copy_pkg;

  localparam int CopySrcAddrWidth = 20;
  localparam logic [15:0] TRANSPARENT_COLOR = 16'h07E0;

  typedef struct packed {
    logic [9:0] x_start;
    logic [9:0] x_end;
    logic [9:0] y_start;
    logic [9:0] y_end;
    logic [CopySrcAddrWidth-1:0] src_addr;
  } copy_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RELEASE
  } sched_state_t;

  function automatic logic rect_empty(copy_cmd_t c);
    return (c.x_end <= c.x_start) || (c.y_end <= c.y_start);
  endfunction

endpackage

// File: rtl/copy_cmd_fifo.sv
// Command FIFO for the copy scheduler.
// Head entry is read from registered storage; flush empties it in one cycle.
module copy_cmd_fifo
  import copy_pkg::*;
#(
  parameter int Depth = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  copy_cmd_t                cmd_in,
  input  logic                     pop,
  input  logic                     flush,
  output copy_cmd_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  copy_cmd_t mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] cnt;
  logic do_push;
  logic do_pop;

  assign full    = (cnt == CntW'(Depth));
  assign empty   = (cnt == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= cmd_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/copy_scheduler.sv
// Command queue and sequencer in front of copy_engine.
// Issues one blit at a time: pop, load, run until done, release.
module copy_scheduler
  import copy_pkg::*;
#(
  parameter int SrcAddrWidth = CopySrcAddrWidth,
  parameter int QueueDepth   = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [9:0]                  cmd_x_start,
  input  logic [9:0]                  cmd_x_end,
  input  logic [9:0]                  cmd_y_start,
  input  logic [9:0]                  cmd_y_end,
  input  logic [SrcAddrWidth-1:0]     cmd_src_addr,
  input  logic                        enable,
  input  logic                        flush,
  output logic                        busy,
  output logic                        idle,
  output logic                        drop,
  output logic [$clog2(QueueDepth):0] queue_level,
  output logic [9:0]                  ce_dest_x_start,
  output logic [9:0]                  ce_dest_x_end,
  output logic [9:0]                  ce_dest_y_start,
  output logic [9:0]                  ce_dest_y_end,
  output logic [SrcAddrWidth-1:0]     ce_src_addr_start,
  output logic                        ce_execute,
  input  logic                        ce_done
);

  copy_cmd_t    cmd_in;
  copy_cmd_t    head;
  logic         full;
  logic         empty;
  logic         pop;
  sched_state_t state;
  sched_state_t state_nxt;

  assign cmd_in = '{
    x_start:  cmd_x_start,
    x_end:    cmd_x_end,
    y_start:  cmd_y_start,
    y_end:    cmd_y_end,
    src_addr: cmd_src_addr
  };

  copy_cmd_fifo #(
    .Depth (QueueDepth)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_valid),
    .cmd_in  (cmd_in),
    .pop     (pop),
    .flush   (flush),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (queue_level)
  );

  assign cmd_ready  = !full;
  assign pop        = (state == S_IDLE) && enable && !empty && !flush;
  assign busy       = (state != S_IDLE);
  assign idle       = empty && (state == S_IDLE);
  // Decoded from the state flop so reset drops execute without a clock
  assign ce_execute = (state == S_RUN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (pop && !rect_empty(head)) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_RUN;
      S_RUN:     if (ce_done) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (flush && (state == S_LOAD || state == S_RUN)) state_nxt = S_RELEASE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      drop              <= 1'b0;
      ce_dest_x_start   <= '0;
      ce_dest_x_end     <= '0;
      ce_dest_y_start   <= '0;
      ce_dest_y_end     <= '0;
      ce_src_addr_start <= '0;
    end else begin
      state <= state_nxt;
      drop  <= pop && rect_empty(head);
      if (pop) begin
        ce_dest_x_start   <= head.x_start;
        ce_dest_x_end     <= head.x_end;
        ce_dest_y_start   <= head.y_start;
        ce_dest_y_end     <= head.y_end;
        ce_src_addr_start <= head.src_addr;
      end
    end
  end

endmodule
